// File: rtl/sfm_seq_pkg.sv
// rtl/sfm_seq_pkg.sv - shared states, SERFM bit indices and timer width for the program sequencer
package sfm_seq_pkg;

    localparam int SFM_TMR_W = 20;
    localparam int SFM_TMR_MAX = (2 ** SFM_TMR_W) - 1;

    localparam int SFM_LOADFINEDLY = 0;
    localparam int SFM_LOADID      = 1;
    localparam int SFM_LOADFEBDLY  = 2;
    localparam int SFM_PROGRAM     = 3;
    localparam int SFM_LOADWP      = 9;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_LD_FEB     = 4'd1,
        ST_LD_ID      = 4'd2,
        ST_LD_FINE    = 4'd3,
        ST_SNAP       = 4'd4,
        ST_WP_OFF     = 4'd5,
        ST_PROG       = 4'd6,
        ST_WRITE_WAIT = 4'd7,
        ST_WP_ON      = 4'd8,
        ST_RELOAD     = 4'd9,
        ST_READ_WAIT  = 4'd10,
        ST_CHECK      = 4'd11
    } sfm_state_e;

endpackage

// File: rtl/sfm_seq_timer.sv
// rtl/sfm_seq_timer.sv - loadable down-counter with zero flag for sequencer state timing
module sfm_seq_timer
    import sfm_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [SFM_TMR_W-1:0] load_val,
    output logic [SFM_TMR_W-1:0] count,
    output logic                 zero
);

    // Load wins over counting; the counter parks at zero until reloaded
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sfm_prog_seq.sv
// rtl/sfm_prog_seq.sv - serial flash program-and-verify sequencer (optional WP toggling: SFM_WP_TOGGLE_EN)
module sfm_prog_seq
    import sfm_seq_pkg::*;
#(
    parameter int LOAD_CYC   = 8,
    parameter int SNAP_DLY   = 6,
    parameter int PROG_CYC   = 320,
    parameter int WRITE_WAIT = 200000,
    parameter int READ_WAIT  = 400
) (
    input  logic        CLKCMS,
    input  logic        RST,
    input  logic        START,
    input  logic [39:0] SFMDOUT,
    output logic [10:0] SERFM_SEQ,
    output logic        SFM_RELOAD,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic        FAIL,
    output logic [39:0] ERRBITS,
    output logic [3:0]  SEQ_STATE
);

    if (LOAD_CYC < 2 || LOAD_CYC > SFM_TMR_MAX || SNAP_DLY < 0 || SNAP_DLY > SFM_TMR_MAX ||
        PROG_CYC < 1 || PROG_CYC > SFM_TMR_MAX || WRITE_WAIT < 1 || WRITE_WAIT > SFM_TMR_MAX ||
        READ_WAIT < 1 || READ_WAIT > SFM_TMR_MAX) begin : g_bad_param
        $error("sfm_prog_seq: timing parameter out of range");
    end

    sfm_state_e           state;
    sfm_state_e           nxt;
    logic                 start_q;
    logic                 start_rise;
    logic                 adv;
    logic [39:0]          snap;
    logic [SFM_TMR_W-1:0] tmr_val;
    logic [SFM_TMR_W-1:0] tmr_count;
    logic                 tmr_zero;

    // Fixed walk through the sequence; WP states exist only when the flash WP is toggled here
    function automatic sfm_state_e next_of(input sfm_state_e s);
        case (s)
            ST_IDLE:       next_of = ST_LD_FEB;
            ST_LD_FEB:     next_of = ST_LD_ID;
            ST_LD_ID:      next_of = ST_LD_FINE;
            ST_LD_FINE:    next_of = ST_SNAP;
`ifdef SFM_WP_TOGGLE_EN
            ST_SNAP:       next_of = ST_WP_OFF;
            ST_WP_OFF:     next_of = ST_PROG;
            ST_PROG:       next_of = ST_WRITE_WAIT;
            ST_WRITE_WAIT: next_of = ST_WP_ON;
            ST_WP_ON:      next_of = ST_RELOAD;
`else
            ST_SNAP:       next_of = ST_PROG;
            ST_PROG:       next_of = ST_WRITE_WAIT;
            ST_WRITE_WAIT: next_of = ST_RELOAD;
`endif
            ST_RELOAD:     next_of = ST_READ_WAIT;
            ST_READ_WAIT:  next_of = ST_CHECK;
            default:       next_of = ST_IDLE;
        endcase
    endfunction

    // Timer preload so that the state lasts (value + 1) cycles; strobe states include the gap cycle
    function automatic logic [SFM_TMR_W-1:0] dur_of(input sfm_state_e s);
        case (s)
            ST_LD_FEB, ST_LD_ID, ST_LD_FINE,
            ST_WP_OFF, ST_WP_ON: dur_of = SFM_TMR_W'(LOAD_CYC);
            ST_SNAP:             dur_of = SFM_TMR_W'(SNAP_DLY);
            ST_PROG:             dur_of = SFM_TMR_W'(PROG_CYC);
            ST_WRITE_WAIT:       dur_of = SFM_TMR_W'(WRITE_WAIT - 1);
            ST_RELOAD:           dur_of = SFM_TMR_W'(1);
            ST_READ_WAIT:        dur_of = SFM_TMR_W'(READ_WAIT - 1);
            default:             dur_of = '0;
        endcase
    endfunction

    // SERFM bit raised on entry to each strobe state
    function automatic logic [10:0] strobe_of(input sfm_state_e s);
        strobe_of = '0;
        case (s)
            ST_LD_FEB:           strobe_of[SFM_LOADFEBDLY]  = 1'b1;
            ST_LD_ID:            strobe_of[SFM_LOADID]      = 1'b1;
            ST_LD_FINE:          strobe_of[SFM_LOADFINEDLY] = 1'b1;
            ST_WP_OFF, ST_WP_ON: strobe_of[SFM_LOADWP]      = 1'b1;
            ST_PROG:             strobe_of[SFM_PROGRAM]     = 1'b1;
            default:             strobe_of = '0;
        endcase
    endfunction

    assign start_rise = START & ~start_q;
    assign SEQ_STATE  = state;

    // Advance condition and timer preload for the state about to be entered
    always_comb begin
        adv     = 1'b0;
        nxt     = next_of(state);
        tmr_val = dur_of(nxt);
        case (state)
            ST_IDLE:  adv = start_rise;
            ST_CHECK: adv = 1'b1;
            default:  adv = tmr_zero;
        endcase
    end

    sfm_seq_timer u_timer (
        .clk      (CLKCMS),
        .rst      (RST),
        .load     (adv),
        .load_val (tmr_val),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    // Sequencer state, registered strobes and the verify result
    always_ff @(posedge CLKCMS) begin
        if (RST) begin
            state      <= ST_IDLE;
            start_q    <= START;
            snap       <= '0;
            SERFM_SEQ  <= '0;
            SFM_RELOAD <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            FAIL       <= 1'b0;
            ERRBITS    <= '0;
        end else begin
            start_q <= START;
            DONE    <= 1'b0;
            if (adv) begin
                state      <= nxt;
                SERFM_SEQ  <= strobe_of(nxt);
                SFM_RELOAD <= (nxt == ST_RELOAD);
                BUSY       <= (nxt != ST_IDLE);
                case (state)
                    ST_IDLE: begin
                        PASS    <= 1'b0;
                        FAIL    <= 1'b0;
                        ERRBITS <= '0;
                    end
                    ST_SNAP:  snap <= SFMDOUT;
                    ST_CHECK: begin
                        ERRBITS <= snap ^ SFMDOUT;
                        PASS    <= (snap == SFMDOUT);
                        FAIL    <= (snap != SFMDOUT);
                        DONE    <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (state == ST_PROG || tmr_count == SFM_TMR_W'(1)) begin
                // program is a single-cycle pulse; load strobes drop one cycle early to form the gap
                SERFM_SEQ <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sfm_prog_seq.sv
// tb/tb_sfm_prog_seq.sv - randomized self-checking bench for sfm_prog_seq
module tb_sfm_prog_seq;

    localparam int LC = 4;
    localparam int SD = 6;
    localparam int PC = 20;
    localparam int WW = 10;
    localparam int RW = 30;
`ifdef SFM_WP_TOGGLE_EN
    localparam int WP_EXTRA = 2 * (LC + 1);
`else
    localparam int WP_EXTRA = 0;
`endif
    localparam int LAT      = 1 + 3 * (LC + 1) + SD + 1 + (1 + PC) + WW + 2 + RW + 1 + WP_EXTRA;
    localparam int RW_START = LAT - 1 - RW;
    localparam int WW_START = 1 + 3 * (LC + 1) + SD + 1 + (1 + PC) + WP_EXTRA / 2;

    logic        CLKCMS = 1'b0;
    logic        RST;
    logic        START;
    logic [39:0] SFMDOUT;
    logic [10:0] SERFM_SEQ;
    logic        SFM_RELOAD;
    logic        BUSY;
    logic        DONE;
    logic        PASS;
    logic        FAIL;
    logic [39:0] ERRBITS;
    logic [3:0]  SEQ_STATE;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLKCMS = ~CLKCMS;

    sfm_prog_seq #(
        .LOAD_CYC   (LC),
        .SNAP_DLY   (SD),
        .PROG_CYC   (PC),
        .WRITE_WAIT (WW),
        .READ_WAIT  (RW)
    ) dut (
        .CLKCMS     (CLKCMS),
        .RST        (RST),
        .START      (START),
        .SFMDOUT    (SFMDOUT),
        .SERFM_SEQ  (SERFM_SEQ),
        .SFM_RELOAD (SFM_RELOAD),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .PASS       (PASS),
        .FAIL       (FAIL),
        .ERRBITS    (ERRBITS),
        .SEQ_STATE  (SEQ_STATE)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: single START pulse, 1: extra START pulses while busy, 2: START held through DONE
    task automatic run_seq(input logic [39:0] base, input logic [39:0] flip, input int mode);
        int          exp_b[$];
        int          exp_w[$];
        int          pb[$];
        int          pw[$];
        int          cur_w[11];
        logic [10:0] prev;
        int          done_cyc;
        int          ndone;
        int          rel_w;
        exp_b = {SFM_B(2), SFM_B(1), SFM_B(0)};
        exp_w = {LC, LC, LC};
`ifdef SFM_WP_TOGGLE_EN
        exp_b.push_back(9); exp_w.push_back(LC);
`endif
        exp_b.push_back(3); exp_w.push_back(1);
`ifdef SFM_WP_TOGGLE_EN
        exp_b.push_back(9); exp_w.push_back(LC);
`endif
        for (int b = 0; b < 11; b++) cur_w[b] = 0;
        prev = '0;
        done_cyc = -1;
        ndone = 0;
        rel_w = 0;
        SFMDOUT = base;
        @(negedge CLKCMS);
        START = 1'b1;
        for (int c = 1; c <= LAT + 10; c++) begin
            @(negedge CLKCMS);
            if (c == 1) begin
                chk("busy_at_cycle1", {63'd0, BUSY}, 64'd1);
                chk("febdly_at_cycle1", {53'd0, SERFM_SEQ}, 64'h4);
            end
            for (int b = 0; b < 11; b++) begin
                if (SERFM_SEQ[b]) cur_w[b]++;
                if (prev[b] && !SERFM_SEQ[b]) begin
                    pb.push_back(b);
                    pw.push_back(cur_w[b]);
                    cur_w[b] = 0;
                end
            end
            if (SFM_RELOAD) rel_w++;
            if (DONE) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            prev = SERFM_SEQ;
            if (mode != 2) START = (mode == 1) && (c == 10 || c == 40);
            if (c == RW_START + 5) SFMDOUT = base ^ flip;
        end
        chk("pulse_count", 64'(pb.size()), 64'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < pb.size(); i++) begin
            chk($sformatf("pulse%0d_bit", i), 64'(pb[i]), 64'(exp_b[i]));
            chk($sformatf("pulse%0d_width", i), 64'(pw[i]), 64'(exp_w[i]));
        end
        chk("done_latency", 64'(done_cyc), 64'(LAT));
        chk("done_count", 64'(ndone), 64'd1);
        chk("reload_width", 64'(rel_w), 64'd2);
        chk("pass", {63'd0, PASS}, {63'd0, (flip == 40'd0)});
        chk("fail", {63'd0, FAIL}, {63'd0, (flip != 40'd0)});
        chk("errbits", {24'd0, ERRBITS}, {24'd0, flip});
        chk("busy_after_done", {63'd0, BUSY}, 64'd0);
        START = 1'b0;
    endtask

    function automatic int SFM_B(input int b);
        return b;
    endfunction

    initial begin
        logic [39:0] rb;
        logic [39:0] rf;
        RST = 1'b1;
        START = 1'b0;
        SFMDOUT = '0;
        repeat (3) @(negedge CLKCMS);
        chk("rst_state", {60'd0, SEQ_STATE}, 64'd0);
        chk("rst_serfm", {53'd0, SERFM_SEQ}, 64'd0);
        chk("rst_busy", {63'd0, BUSY}, 64'd0);
        chk("rst_done", {63'd0, DONE}, 64'd0);
        chk("rst_pass_fail", {62'd0, PASS, FAIL}, 64'd0);
        chk("rst_errbits", {24'd0, ERRBITS}, 64'd0);
        chk("rst_reload", {63'd0, SFM_RELOAD}, 64'd0);
        RST = 1'b0;
        @(negedge CLKCMS);

        run_seq(40'hA5_1234_5678, 40'h0, 0);
        run_seq(40'hA5_1234_5678, 40'h1, 0);
        for (int i = 0; i < 3; i++) begin
            rb = {8'($urandom), 32'($urandom)};
            rf = (i == 0) ? 40'h0 : ({8'($urandom), 32'($urandom)} | 40'h1);
            run_seq(rb, rf, 0);
        end
        rb = {8'($urandom), 32'($urandom)};
        run_seq(rb, 40'h0, 1);
        rb = {8'($urandom), 32'($urandom)};
        rf = {8'($urandom), 32'($urandom)} | (40'h1 << $urandom_range(39, 0));
        run_seq(rb, rf, 2);
        repeat (5) @(negedge CLKCMS);
        chk("no_retrigger_idle", {63'd0, BUSY}, 64'd0);

        @(negedge CLKCMS);
        START = 1'b1;
        for (int c = 1; c <= WW_START + 3; c++) begin
            @(negedge CLKCMS);
            START = 1'b0;
        end
        chk("in_write_wait_busy", {63'd0, BUSY}, 64'd1);
        RST = 1'b1;
        @(negedge CLKCMS);
        RST = 1'b0;
        chk("midrst_state", {60'd0, SEQ_STATE}, 64'd0);
        chk("midrst_serfm", {53'd0, SERFM_SEQ}, 64'd0);
        chk("midrst_busy", {63'd0, BUSY}, 64'd0);
        chk("midrst_pass_fail", {62'd0, PASS, FAIL}, 64'd0);

        @(negedge CLKCMS);
        RST = 1'b1;
        START = 1'b1;
        @(negedge CLKCMS);
        RST = 1'b0;
        START = 1'b0;
        chk("rst_start_state", {60'd0, SEQ_STATE}, 64'd0);
        repeat (3) @(negedge CLKCMS);
        chk("rst_start_busy", {63'd0, BUSY}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
